// File: rtl/huff_decoder.sv
// rtl/huff_decoder.sv - Huffman table loader and serial MSB-first code decoder on a 12-bit io bus
module huff_decoder #(
  parameter int MAX_CHAR_COUNT = 3,
  parameter int CODE_W         = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] io_in,
  output logic [11:0] io_out
);

  localparam int IDX_W = (MAX_CHAR_COUNT > 1) ? $clog2(MAX_CHAR_COUNT) : 1;
  localparam int LEN_W = $clog2(CODE_W + 1);

  typedef enum logic [1:0] {
    LOAD_CHAR,
    LOAD_CODE,
    DECODE
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]  idx;
  logic [CODE_W-1:0] acc;
  logic [LEN_W-1:0]  len;
  logic [4:0]        chars  [MAX_CHAR_COUNT];
  logic [CODE_W-1:0] masks  [MAX_CHAR_COUNT];
  logic [CODE_W-1:0] values [MAX_CHAR_COUNT];
  logic              sym_valid;
  logic              err;
  logic              table_ready;
  logic [4:0]        char_out;

  logic              strobe;
  logic              restart;
  logic              tag_ok;
  logic              last_entry;
  logic [CODE_W-1:0] new_acc;
  logic [LEN_W-1:0]  new_len;
  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic              unused_bits;

  assign strobe      = io_in[11];
  assign restart     = io_in[10];
  assign tag_ok      = (io_in[7:5] == 3'b011);
  assign last_entry  = (idx == IDX_W'(MAX_CHAR_COUNT - 1));
  assign new_acc     = {acc[CODE_W-2:0], io_in[0]};
  assign new_len     = len + LEN_W'(1);
  assign unused_bits = ^io_in[9:8];

  function automatic logic [LEN_W-1:0] popcount(input logic [CODE_W-1:0] m);
    logic [LEN_W-1:0] c;
    c = '0;
    for (int b = 0; b < CODE_W; b++) c = c + LEN_W'(m[b]);
    return c;
  endfunction

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = MAX_CHAR_COUNT - 1; i >= 0; i--) begin
      if ((masks[i] != '0) && (popcount(masks[i]) == new_len) &&
          ((new_acc & masks[i]) == values[i])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD_CHAR;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (restart) begin
      state_next = LOAD_CHAR;
    end else if (strobe) begin
      case (state)
        LOAD_CHAR: if (tag_ok) state_next = LOAD_CODE;
        LOAD_CODE: state_next = last_entry ? DECODE : LOAD_CHAR;
        DECODE:    state_next = DECODE;
        default:   state_next = LOAD_CHAR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      acc         <= '0;
      len         <= '0;
      sym_valid   <= 1'b0;
      err         <= 1'b0;
      table_ready <= 1'b0;
      char_out    <= '0;
      for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
        chars[i]  <= '0;
        masks[i]  <= '0;
        values[i] <= '0;
      end
    end else begin
      sym_valid <= 1'b0;
      if (restart) begin
        idx         <= '0;
        acc         <= '0;
        len         <= '0;
        err         <= 1'b0;
        table_ready <= 1'b0;
        for (int i = 0; i < MAX_CHAR_COUNT; i++) masks[i] <= '0;
      end else if (strobe) begin
        case (state)
          LOAD_CHAR: begin
            if (tag_ok) chars[idx] <= io_in[4:0];
            else        err        <= 1'b1;
          end
          LOAD_CODE: begin
            masks[idx]  <= io_in[5:3];
            values[idx] <= io_in[2:0];
            if (last_entry) begin
              idx         <= '0;
              table_ready <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          DECODE: begin
            if (hit) begin
              sym_valid <= 1'b1;
              char_out  <= chars[hit_idx];
              acc       <= '0;
              len       <= '0;
            end else if (new_len == LEN_W'(CODE_W)) begin
              err <= 1'b1;
              acc <= '0;
              len <= '0;
            end else begin
              acc <= new_acc;
              len <= new_len;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign io_out = {sym_valid, err, table_ready, 4'b0000, char_out};

endmodule

// File: tb/tb_huff_decoder.sv
// tb/tb_huff_decoder.sv - directed self-checking bench for huff_decoder
module tb_huff_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] io_in;
  logic [11:0] io_out;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  huff_decoder #(.MAX_CHAR_COUNT(3), .CODE_W(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_in  (io_in),
    .io_out (io_out)
  );

  // One word held for exactly one rising edge; io_out sampled 1 ns later.
  task automatic send(input logic [11:0] w);
    @(negedge clk);
    io_in = w;
    @(posedge clk);
    #1;
    io_in = 12'h000;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    io_in = 12'h000;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (io_out !== 12'h000) begin
      $display("FAIL reset io_out got %h want %h", io_out, 12'h000);
      n_bad++;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_table_load;
    logic [11:0] stim [6] = '{12'h861, 12'h808, 12'h862, 12'h81A, 12'h863, 12'h81B};
    logic [11:0] want [6] = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h200};
    for (int i = 0; i < 6; i++) begin
      send(stim[i]);
      n_cmp++;
      if (io_out !== want[i]) begin
        $display("FAIL table_load[%0d] got %h want %h", i, io_out, want[i]);
        n_bad++;
      end
    end
  endtask

  task automatic test_decode;
    logic [11:0] stim [7] = '{12'h800, 12'h801, 12'h800, 12'h801, 12'h801, 12'h000, 12'h800};
    logic [11:0] want [7] = '{12'hA01, 12'h201, 12'hA02, 12'h202, 12'hA03, 12'h203, 12'hA01};
    for (int i = 0; i < 7; i++) begin
      send(stim[i]);
      n_cmp++;
      if (io_out !== want[i]) begin
        $display("FAIL decode[%0d] got %h want %h", i, io_out, want[i]);
        n_bad++;
      end
    end
  endtask

  task automatic test_overlength;
    logic [11:0] stim [11] = '{12'h400, 12'h861, 12'h808, 12'h862, 12'h81A, 12'h863,
                               12'h83F, 12'h801, 12'h801, 12'h800, 12'h800};
    logic [11:0] want [11] = '{12'h001, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001,
                               12'h201, 12'h201, 12'h201, 12'h601, 12'hE01};
    for (int i = 0; i < 11; i++) begin
      send(stim[i]);
      n_cmp++;
      if (io_out !== want[i]) begin
        $display("FAIL overlength[%0d] got %h want %h", i, io_out, want[i]);
        n_bad++;
      end
    end
  endtask

  task automatic test_bad_tag;
    logic [11:0] stim [11] = '{12'h400, 12'h841, 12'h861, 12'h808, 12'h862, 12'h81A,
                               12'h863, 12'h81B, 12'h801, 12'h800, 12'h800};
    logic [11:0] want [11] = '{12'h001, 12'h401, 12'h401, 12'h401, 12'h401, 12'h401,
                               12'h401, 12'h601, 12'h601, 12'hE02, 12'hE01};
    for (int i = 0; i < 11; i++) begin
      send(stim[i]);
      n_cmp++;
      if (io_out !== want[i]) begin
        $display("FAIL bad_tag[%0d] got %h want %h", i, io_out, want[i]);
        n_bad++;
      end
    end
  endtask

  task automatic test_restart_strobe;
    logic [11:0] stim [10] = '{12'h801, 12'hC01, 12'h861, 12'h808, 12'h862, 12'h81A,
                               12'h863, 12'h81B, 12'h801, 12'h801};
    logic [11:0] want [10] = '{12'h601, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001,
                               12'h001, 12'h201, 12'h201, 12'hA03};
    for (int i = 0; i < 10; i++) begin
      send(stim[i]);
      n_cmp++;
      if (io_out !== want[i]) begin
        $display("FAIL restart_strobe[%0d] got %h want %h", i, io_out, want[i]);
        n_bad++;
      end
    end
  endtask

  task automatic test_async_reset;
    logic [11:0] stim [7] = '{12'h861, 12'h808, 12'h862, 12'h81A, 12'h863, 12'h81B, 12'h800};
    logic [11:0] want [7] = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h200, 12'hA01};
    send(12'h400);
    send(12'h861);
    n_cmp++;
    if (io_out !== 12'h003) begin
      $display("FAIL async_pre got %h want %h", io_out, 12'h003);
      n_bad++;
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (io_out !== 12'h000) begin
      $display("FAIL async_reset got %h want %h", io_out, 12'h000);
      n_bad++;
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send(stim[i]);
      n_cmp++;
      if (io_out !== want[i]) begin
        $display("FAIL async_reload[%0d] got %h want %h", i, io_out, want[i]);
        n_bad++;
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] stim [5] = '{12'h800, 12'h800, 12'h801, 12'h801, 12'h800};
    logic [11:0] want [5] = '{12'hA01, 12'hA01, 12'h201, 12'hA03, 12'hA01};
    for (int i = 0; i < 5; i++) begin
      send(stim[i]);
      n_cmp++;
      if (io_out !== want[i]) begin
        $display("FAIL back_to_back[%0d] got %h want %h", i, io_out, want[i]);
        n_bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_table_load();
    test_decode();
    test_overlength();
    test_bad_tag();
    test_restart_strobe();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
